// File: rtl/dmx_pkg.sv
// Shared constants and FSM encoding for the DMX universe loader.
package dmx_pkg;

  localparam logic [7:0]  SYNC_BYTE        = 8'hAA;
  localparam int unsigned DEFAULT_CHANNELS = 512;
  localparam int unsigned CH_AW            = 9;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StCntHi,
    StCntLo,
    StData,
    StZfill,
    StCsumEval
  } dmx_state_e;

endpackage

// File: rtl/dmx_universe_ram.sv
// Double-buffered universe store: one write port (with both-bank clear) and a
// registered read port.
module dmx_universe_ram
  import dmx_pkg::*;
#(
  parameter int unsigned CHANNELS = DEFAULT_CHANNELS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic             clr,
  input  logic             wr_bank,
  input  logic [CH_AW-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             rd_bank,
  input  logic [CH_AW-1:0] rd_addr,
  input  logic             rd_zero,
  output logic [7:0]       rd_data
);

  logic [7:0] bank0 [CHANNELS];
  logic [7:0] bank1 [CHANNELS];
  logic [7:0] rd_data_q;

  // clr writes the same zero into both banks in a single cycle.
  always_ff @(posedge clock) begin
    if (clr || (we && !wr_bank)) begin
      bank0[wr_addr] <= clr ? 8'h00 : wr_data;
    end
    if (clr || (we && wr_bank)) begin
      bank1[wr_addr] <= clr ? 8'h00 : wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= 8'h00;
    end else if (rd_zero) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= rd_bank ? bank1[rd_addr] : bank0[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dmx_universe_loader.sv
// Parses framed universe packets from the UART byte stream into the back bank
// and swaps banks only on a transmitter frame boundary.
module dmx_universe_loader
  import dmx_pkg::*;
#(
  parameter int unsigned CHANNELS       = DEFAULT_CHANNELS,
  parameter int unsigned TIMEOUT_CYCLES = 12000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             frame_start,
  input  logic [CH_AW-1:0] rd_addr,
  output logic [7:0]       rd_data,
  output logic             active_bank,
  output logic             pkt_ok,
  output logic             pkt_err
);

  localparam int unsigned PtrW = $clog2(CHANNELS + 1);
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PtrW-1:0] ChanLast = PtrW'(CHANNELS - 1);
  localparam logic [PtrW-1:0] ChanEnd  = PtrW'(CHANNELS);
  localparam logic [TmrW-1:0] TmrFire  = TmrW'(TIMEOUT_CYCLES - 1);

  dmx_state_e      state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] count_q, count_d;
  logic [7:0]      cnt_hi_q, cnt_hi_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      csum_q, csum_d;
  logic            csum_held_q, csum_held_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic            active_q, active_d;
  logic            pending_q, pending_d;
  logic            pkt_ok_q, pkt_ok_d;
  logic            pkt_err_q, pkt_err_d;

  logic            ram_we, ram_clr;
  logic [7:0]      ram_wdata;
  logic            rd_zero;
  logic [15:0]     count_full;
  logic [7:0]      sum_plus;
  logic [7:0]      csum_total;
  logic            timed;

  assign count_full = {cnt_hi_q, rx_data};
  assign sum_plus   = sum_q + rx_data;
  assign csum_total = sum_q + csum_q;
  assign rd_zero    = (state_q == StClear) || (32'(rd_addr) >= CHANNELS);

  // Inter-byte timeout applies inside a packet and while the checksum is outstanding.
  assign timed = (state_q == StCntHi) || (state_q == StCntLo) || (state_q == StData) ||
                 ((state_q == StZfill) && !csum_held_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    cnt_hi_d    = cnt_hi_q;
    sum_d       = sum_q;
    csum_d      = csum_q;
    csum_held_d = csum_held_q;
    timer_d     = timer_q;
    active_d    = active_q;
    pending_d   = pending_q;
    pkt_ok_d    = 1'b0;
    pkt_err_d   = 1'b0;
    ram_we      = 1'b0;
    ram_clr     = 1'b0;
    ram_wdata   = 8'h00;

    // A commit in the same cycle sets pending_d below, so it survives to the next frame.
    if (frame_start && pending_q) begin
      active_d  = ~active_q;
      pending_d = 1'b0;
    end

    case (state_q)
      StClear: begin
        ram_clr = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        if (ptr_q == ChanLast) begin
          ptr_d   = '0;
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          sum_d   = 8'h00;
          timer_d = TmrW'(1);
          state_d = StCntHi;
        end
      end
      StCntHi: begin
        if (rx_valid) begin
          cnt_hi_d = rx_data;
          sum_d    = sum_plus;
          state_d  = StCntLo;
        end
      end
      StCntLo: begin
        if (rx_valid) begin
          sum_d = sum_plus;
          if ((count_full == 16'h0000) || (count_full > 16'(CHANNELS))) begin
            pkt_err_d = 1'b1;
            state_d   = StIdle;
          end else begin
            count_d     = PtrW'(count_full);
            ptr_d       = '0;
            csum_held_d = 1'b0;
            state_d     = StData;
          end
        end
      end
      StData: begin
        if (rx_valid) begin
          if (ptr_q == count_q) begin
            csum_d  = rx_data;
            state_d = StCsumEval;
          end else begin
            ram_we    = 1'b1;
            ram_wdata = rx_data;
            sum_d     = sum_plus;
            pending_d = 1'b0;
            ptr_d     = ptr_q + 1'b1;
            if ((ptr_d == count_q) && (count_q != ChanEnd)) begin
              state_d = StZfill;
            end
          end
        end
      end
      StZfill: begin
        if (ptr_q != ChanEnd) begin
          ram_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
        end
        if (rx_valid && !csum_held_q) begin
          csum_d      = rx_data;
          csum_held_d = 1'b1;
        end
        if ((ptr_q == ChanEnd) && csum_held_q) begin
          state_d = StCsumEval;
        end
      end
      StCsumEval: begin
        if (csum_total == 8'h00) begin
          pkt_ok_d  = 1'b1;
          pending_d = 1'b1;
        end else begin
          pkt_err_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StClear;
    endcase

    if (timed) begin
      if (rx_valid) begin
        timer_d = TmrW'(1);
      end else if (timer_q == TmrFire) begin
        pkt_err_d = 1'b1;
        state_d   = StIdle;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StClear;
      ptr_q       <= '0;
      count_q     <= '0;
      cnt_hi_q    <= 8'h00;
      sum_q       <= 8'h00;
      csum_q      <= 8'h00;
      csum_held_q <= 1'b0;
      timer_q     <= '0;
      active_q    <= 1'b0;
      pending_q   <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      cnt_hi_q    <= cnt_hi_d;
      sum_q       <= sum_d;
      csum_q      <= csum_d;
      csum_held_q <= csum_held_d;
      timer_q     <= timer_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_err_q   <= pkt_err_d;
    end
  end

  dmx_universe_ram #(
    .CHANNELS (CHANNELS)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .we      (ram_we),
    .clr     (ram_clr),
    .wr_bank (~active_q),
    .wr_addr (CH_AW'(ptr_q)),
    .wr_data (ram_wdata),
    .rd_bank (active_q),
    .rd_addr (rd_addr),
    .rd_zero (rd_zero),
    .rd_data (rd_data)
  );

  assign active_bank = active_q;
  assign pkt_ok      = pkt_ok_q;
  assign pkt_err     = pkt_err_q;

endmodule

// File: tb/tb_dmx_universe_loader.sv
// Directed bench for dmx_universe_loader: clear, commit, zero-fill, checksum,
// timeout, header rejection and frame-boundary swapping.
module tb_dmx_universe_loader;

  localparam int unsigned T = 12000;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_start;
  logic [8:0] rd_addr;
  logic [7:0] rd_data;
  logic       active_bank;
  logic       pkt_ok;
  logic       pkt_err;

  int checks  = 0;
  int errors  = 0;
  int ok_cnt  = 0;
  int err_cnt = 0;

  always #5 clock = ~clock;

  dmx_universe_loader #(
    .CHANNELS       (512),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_start (frame_start),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .active_bank (active_bank),
    .pkt_ok      (pkt_ok),
    .pkt_err     (pkt_err)
  );

  // Cycles each pulse is high; a stretched pulse shows up as an extra count.
  always @(posedge clock) begin
    if (pkt_ok)  ok_cnt  <= ok_cnt + 1;
    if (pkt_err) err_cnt <= err_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step(1);
    rx_valid = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [8:0] addr, input logic [7:0] exp);
    rd_addr = addr;
    step(1);
    chk(tag, {24'h0, rd_data}, {24'h0, exp});
  endtask

  task automatic fs();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    frame_start = 1'b0;
    rd_addr     = 9'd5;
    step(3);
    chk("reset_rd_data", {24'h0, rd_data}, 32'h0);
    chk("reset_active", {31'h0, active_bank}, 32'h0);
    chk("reset_pkt_ok", {31'h0, pkt_ok}, 32'h0);
    chk("reset_pkt_err", {31'h0, pkt_err}, 32'h0);
    reset = 1'b0;
    step(10);
    chk("clear_rd_zero", {24'h0, rd_data}, 32'h0);
    step(520);
    chk_rd("post_clear_ch5", 9'd5, 8'h00);
    chk("post_clear_ok", ok_cnt, 0);
    chk("post_clear_err", err_cnt, 0);

    // Full 512-channel packet, data i&0xFF; sum = 0x02, checksum 0xFE.
    send(8'hAA); send(8'h02); send(8'h00);
    for (int i = 0; i < 512; i++) send(8'(i));
    send(8'hFE);
    chk("full_ok_early", {31'h0, pkt_ok}, 32'h0);
    step(1);
    chk("full_ok_pulse", {31'h0, pkt_ok}, 32'h1);
    step(1);
    chk("full_ok_drop", {31'h0, pkt_ok}, 32'h0);
    chk("full_ok_cnt", ok_cnt, 1);
    chk("full_no_swap", {31'h0, active_bank}, 32'h0);
    chk_rd("full_old_bank_ch10", 9'd10, 8'h00);
    fs();
    chk("full_swap", {31'h0, active_bank}, 32'h1);
    chk_rd("full_ch10", 9'd10, 8'h0A);
    chk_rd("full_ch511", 9'd511, 8'hFF);

    // All-0xFF packet to bank 0, frame_start coincident with commit.
    send(8'hAA); send(8'h02); send(8'h00);
    for (int i = 0; i < 512; i++) send(8'hFF);
    send(8'hFE);
    fs();
    chk("coinc_ok_pulse", {31'h0, pkt_ok}, 32'h1);
    chk("coinc_no_swap", {31'h0, active_bank}, 32'h1);
    step(3);
    fs();
    chk("coinc_next_swap", {31'h0, active_bank}, 32'h0);
    chk_rd("ff_ch300", 9'd300, 8'hFF);

    // Short packet into bank 1 (which holds i&0xFF): tail must be zero-filled.
    send(8'hAA); send(8'h00); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33); send(8'h97);
    step(600);
    chk("short_ok_cnt", ok_cnt, 3);
    chk("short_err_cnt", err_cnt, 0);
    chk("short_no_swap", {31'h0, active_bank}, 32'h0);
    fs();
    chk("short_swap", {31'h0, active_bank}, 32'h1);
    chk_rd("short_ch0", 9'd0, 8'h11);
    chk_rd("short_ch1", 9'd1, 8'h22);
    chk_rd("short_ch2", 9'd2, 8'h33);
    chk_rd("short_ch3", 9'd3, 8'h00);
    chk_rd("short_ch255", 9'd255, 8'h00);
    chk_rd("short_ch511", 9'd511, 8'h00);

    // Bad checksum: rejected, no swap.
    send(8'hAA); send(8'h00); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33); send(8'h98);
    step(600);
    chk("badsum_err_cnt", err_cnt, 1);
    chk("badsum_ok_cnt", ok_cnt, 3);
    fs();
    chk("badsum_no_swap", {31'h0, active_bank}, 32'h1);
    chk_rd("badsum_ch1", 9'd1, 8'h22);

    // Timeout: pkt_err in cycle T after the 0x11 byte.
    send(8'hAA); send(8'h00); send(8'h03); send(8'h11);
    step(T - 2);
    chk("tmo_not_early", {31'h0, pkt_err}, 32'h0);
    chk("tmo_no_early_cnt", err_cnt, 1);
    step(1);
    chk("tmo_pulse", {31'h0, pkt_err}, 32'h1);
    step(1);
    chk("tmo_drop", {31'h0, pkt_err}, 32'h0);
    chk("tmo_err_cnt", err_cnt, 2);
    // 00+03+44+55+66 = 0x102 -> checksum 0xFE.
    send(8'hAA); send(8'h00); send(8'h03);
    send(8'h44); send(8'h55); send(8'h66); send(8'hFE);
    step(600);
    chk("post_tmo_ok_cnt", ok_cnt, 4);
    fs();
    chk("post_tmo_swap", {31'h0, active_bank}, 32'h0);
    chk_rd("post_tmo_ch1", 9'd1, 8'h55);
    chk_rd("post_tmo_ch4", 9'd4, 8'h00);

    // Header rejections and idle noise.
    send(8'hAA); send(8'h00); send(8'h00);
    step(2);
    chk("count0_err", err_cnt, 3);
    send(8'hAA); send(8'h02); send(8'h01);
    step(2);
    chk("count513_err", err_cnt, 4);
    send(8'h55); send(8'h00); send(8'h13); send(8'hFF); send(8'h02);
    step(5);
    chk("noise_err", err_cnt, 4);
    chk("noise_ok", ok_cnt, 4);
    send(8'hAA); send(8'h00); send(8'h01); send(8'h5A); send(8'hA5);
    step(600);
    chk("one_ch_ok", ok_cnt, 5);
    fs();
    chk_rd("one_ch_ch0", 9'd0, 8'h5A);
    chk_rd("one_ch_ch1", 9'd1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
